// File: rtl/npc_pc_unit_pkg.sv
// Shared definitions for the next-PC unit: next-PC select encodings and the
// default reset / exception-vector addresses.
package npc_pc_unit_pkg;

    // D_NPCSel encoding produced by the D-stage decoder
    typedef enum logic [1:0] {
        NPC_SEQ = 2'b00,  // fall through (past the delay slot)
        NPC_BR  = 2'b01,  // conditional branch
        NPC_J   = 2'b10,  // j / jal
        NPC_JR  = 2'b11   // jr / jalr
    } npc_sel_e;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC  = 32'h0000_4180;

endpackage

// File: rtl/npc_pc_unit_if.sv
// Signal bundle between the pipeline (decoder, hazard unit, E stage,
// exception unit) and the next-PC unit. The unit itself uses the slave
// modport; the pipeline side uses master.
interface npc_pc_unit_if #(
    parameter int PC_W = 32
);
    // pipeline -> unit
    logic            stall;
    logic [PC_W-1:0] D_PCplus4;
    logic [25:0]     D_Imm26;
    logic [PC_W-1:0] D_RsData;
    logic [1:0]      D_NPCSel;
    logic            D_CMPResult;
    logic            D_Link;
    logic            D_IsRet;
    logic            D_RsHazard;
    logic            E_RetMiss;
    logic [PC_W-1:0] E_RetTarget;
    logic            exc_req;
    logic            eret_req;
    logic [PC_W-1:0] epc;
    // unit -> pipeline
    logic [PC_W-1:0] F_PC;
    logic [PC_W-1:0] D_PCplus8;
    logic            ras_pred;
    logic            ras_flush;
    logic            F_AdEL;

    modport master (
        output stall, D_PCplus4, D_Imm26, D_RsData, D_NPCSel, D_CMPResult,
               D_Link, D_IsRet, D_RsHazard, E_RetMiss, E_RetTarget,
               exc_req, eret_req, epc,
        input  F_PC, D_PCplus8, ras_pred, ras_flush, F_AdEL
    );

    modport slave (
        input  stall, D_PCplus4, D_Imm26, D_RsData, D_NPCSel, D_CMPResult,
               D_Link, D_IsRet, D_RsHazard, E_RetMiss, E_RetTarget,
               exc_req, eret_req, epc,
        output F_PC, D_PCplus8, ras_pred, ras_flush, F_AdEL
    );

endinterface

// File: rtl/npc_ras.sv
// Return-address stack: circular buffer of DEPTH link addresses.
// Top of stack is mem[ptr-1]. A push onto a full stack overwrites the oldest
// entry; a pop on an empty stack does nothing; push+pop in the same cycle
// replaces the top entry and leaves the depth unchanged.
module npc_ras #(
    parameter int PC_W  = 32,
    parameter int DEPTH = 4     // power of two, >= 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] push_data,
    output logic [PC_W-1:0] top,
    output logic            nonempty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] top_idx;
    logic [CNT_W-1:0] count;
    logic             do_pop;

    assign top_idx  = ptr - PTR_W'(1);
    assign top      = mem[top_idx];
    assign nonempty = (count != '0);
    assign do_pop   = pop & nonempty;

    // Pointer and occupancy bookkeeping
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr   <= '0;
            count <= '0;
        end else if (push && do_pop) begin
            // top replaced in place: pointer and depth stay put
        end else if (push) begin
            ptr <= ptr + PTR_W'(1);
            if (count != CNT_W'(DEPTH))
                count <= count + CNT_W'(1);
        end else if (do_pop) begin
            ptr   <= ptr - PTR_W'(1);
            count <= count - CNT_W'(1);
        end
    end

    // Entry storage; a combined push+pop overwrites the current top
    // NOTE: storage is deliberately not reset -- count==0 already marks every entry invalid.
    always_ff @(posedge clk) begin
        if (push)
            mem[do_pop ? top_idx : ptr] <= push_data;
    end

endmodule

// File: rtl/npc_pc_unit.sv
// Next-PC generator and fetch PC register for a MIPS pipeline with branch
// delay slot. Control transfers are resolved in D; redirects from the
// exception unit and from E (return mispredict) override them, and a
// return-address stack predicts jr $ra while rs is still hazarded.
// Optional feature: define NPC_ALIGN_CHK_EN to get a registered fetch
// misalignment flag on F_AdEL; otherwise F_AdEL is tied low.
module npc_pc_unit #(
    parameter int              PC_W      = 32,
    parameter int              RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC  = npc_pc_unit_pkg::RESET_PC,
    parameter logic [PC_W-1:0] EXC_VEC   = npc_pc_unit_pkg::EXC_VEC
) (
    input  logic               clk,
    input  logic               reset_n,
    npc_pc_unit_if.slave       bus
);

    import npc_pc_unit_pkg::*;

    npc_sel_e        sel;
    logic [PC_W-1:0] seq_pc;
    logic [PC_W-1:0] br_off;
    logic [PC_W-1:0] br_pc;
    logic [PC_W-1:0] j_pc;
    logic [PC_W-1:0] jr_pc;
    logic [PC_W-1:0] tgt_pc;
    logic [PC_W-1:0] f_pc_d;
    logic [PC_W-1:0] f_pc_q;
    logic [PC_W-1:0] ras_top;
    logic            ras_nonempty;
    logic            ras_pred;
    logic            redirect;
    logic            ras_en;
    logic            ras_push;
    logic            ras_pop;

    assign sel = npc_sel_e'(bus.D_NPCSel);

    // Candidate targets; all adds wrap modulo 2^PC_W
    assign seq_pc = bus.D_PCplus4 + PC_W'(4);
    assign br_off = {{(PC_W-18){bus.D_Imm26[15]}}, bus.D_Imm26[15:0], 2'b00};
    assign br_pc  = bus.D_PCplus4 + br_off;
    assign j_pc   = {bus.D_PCplus4[PC_W-1:28], bus.D_Imm26, 2'b00};

    // Use the stack top only when rs is not yet available and there is an entry
    assign ras_pred = bus.D_IsRet & bus.D_RsHazard & ras_nonempty;
    assign jr_pc    = ras_pred ? ras_top : bus.D_RsData;

    // Target select from the D-stage decode
    always_comb begin
        // NOTE: default assignment first so no path leaves tgt_pc unassigned (no latch).
        tgt_pc = seq_pc;
        case (sel)
            NPC_SEQ: tgt_pc = seq_pc;
            NPC_BR:  tgt_pc = bus.D_CMPResult ? br_pc : seq_pc;
            NPC_J:   tgt_pc = j_pc;
            NPC_JR:  tgt_pc = jr_pc;
            default: tgt_pc = seq_pc;
        endcase
    end

    assign redirect = bus.exc_req | bus.eret_req | bus.E_RetMiss;

    // Fetch PC source, highest priority first
    always_comb begin
        f_pc_d = tgt_pc;
        if (bus.exc_req)
            f_pc_d = EXC_VEC;
        else if (bus.eret_req)
            f_pc_d = bus.epc;
        else if (bus.E_RetMiss)
            f_pc_d = bus.E_RetTarget;
        else if (bus.stall)
            f_pc_d = f_pc_q;
    end

    // Fetch PC register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            f_pc_q <= RESET_PC;
        else
            f_pc_q <= f_pc_d;
    end

    // The stack only moves on an instruction that actually advances out of D;
    // redirects leave it untouched (no repair on exception or mispredict)
    assign ras_en   = ~bus.stall & ~redirect;
    assign ras_push = ras_en & bus.D_Link;
    assign ras_pop  = ras_en & (sel == NPC_JR) & bus.D_IsRet;

    npc_ras #(
        .PC_W  (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (seq_pc),
        .top       (ras_top),
        .nonempty  (ras_nonempty)
    );

    assign bus.F_PC      = f_pc_q;
    assign bus.D_PCplus8 = seq_pc;
    assign bus.ras_pred  = ras_pred;
    assign bus.ras_flush = bus.E_RetMiss;

`ifdef NPC_ALIGN_CHK_EN
    logic adel_q;

    // Misalignment flag travels with the PC it describes; the PC is still loaded
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            adel_q <= 1'b0;
        else
            adel_q <= |f_pc_d[1:0];
    end

    assign bus.F_AdEL = adel_q;
`else
    assign bus.F_AdEL = 1'b0;
`endif

endmodule

// File: tb/tb_npc_pc_unit.sv
// Self-checking bench for npc_pc_unit: a directed vector table, hand-written
// RAS / redirect / reset sequences, and a randomized phase scored against a
// queue-based reference model of the next-PC rules.
module tb_npc_pc_unit;

    import npc_pc_unit_pkg::*;

    localparam logic [7:0] F_CMP   = 8'h01;
    localparam logic [7:0] F_LINK  = 8'h02;
    localparam logic [7:0] F_ISRET = 8'h04;
    localparam logic [7:0] F_HAZ   = 8'h08;
    localparam logic [7:0] F_STALL = 8'h10;
    localparam logic [7:0] F_EXC   = 8'h20;
    localparam logic [7:0] F_ERET  = 8'h40;
    localparam logic [7:0] F_MISS  = 8'h80;
    localparam int         DEPTH   = 4;

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] pc4;
        logic [25:0] imm;
        logic [31:0] rs;
        logic [7:0]  fl;
        logic [31:0] epc;
        logic [31:0] rtgt;
        logic [31:0] exp_pc;
        logic        exp_pred;
    } vec_t;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_fail;

    // reference model state
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];

    vec_t tbl[17];

    npc_pc_unit_if #(.PC_W(32)) bus ();

    npc_pc_unit #(
        .PC_W      (32),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] sel, input logic [31:0] pc4,
                                input logic [25:0] imm, input logic [31:0] rs,
                                input logic [7:0] fl, input logic [31:0] epc,
                                input logic [31:0] rtgt, input logic [31:0] exp_pc,
                                input logic exp_pred);
        vec_t v;
        v.sel = sel; v.pc4 = pc4; v.imm = imm; v.rs = rs; v.fl = fl;
        v.epc = epc; v.rtgt = rtgt; v.exp_pc = exp_pc; v.exp_pred = exp_pred;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.D_NPCSel    = v.sel;
        bus.D_PCplus4   = v.pc4;
        bus.D_Imm26     = v.imm;
        bus.D_RsData    = v.rs;
        bus.D_CMPResult = v.fl[0];
        bus.D_Link      = v.fl[1];
        bus.D_IsRet     = v.fl[2];
        bus.D_RsHazard  = v.fl[3];
        bus.stall       = v.fl[4];
        bus.exc_req     = v.fl[5];
        bus.eret_req    = v.fl[6];
        bus.E_RetMiss   = v.fl[7];
        bus.epc         = v.epc;
        bus.E_RetTarget = v.rtgt;
    endtask

    // Drive one D-stage cycle, check the combinational outputs, clock it, check F_PC
    task automatic run_vec(input vec_t v, input string tag);
        drive(v);
        #1;
        check({tag, ".pcplus8"}, bus.D_PCplus8, v.pc4 + 32'd4);
        check({tag, ".pred"}, {31'd0, bus.ras_pred}, {31'd0, v.exp_pred});
        check({tag, ".flush"}, {31'd0, bus.ras_flush}, {31'd0, v.fl[7]});
        @(posedge clk);
        #1;
        check({tag, ".fpc"}, bus.F_PC, v.exp_pc);
    endtask

    task automatic do_reset();
        drive(mk(2'd0, 32'd0, 26'd0, 32'd0, 8'd0, 32'd0, 32'd0, 32'd0, 1'b0));
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.fpc", bus.F_PC, 32'h0000_3000);
        check("rst.adel", {31'd0, bus.F_AdEL}, 32'd0);
        reset_n = 1'b1;
        m_pc = 32'h0000_3000;
        m_ras.delete();
    endtask

    // Reference model: next PC and return-stack behaviour from the rules
    task automatic model_fill(inout vec_t v);
        logic [31:0] tgt;
        logic [31:0] nxt;
        int          off;
        bit          pred;
        pred = v.fl[2] && v.fl[3] && (m_ras.size() > 0);
        off  = int'($signed(v.imm[15:0])) * 4;
        case (v.sel)
            2'd0:    tgt = v.pc4 + 32'd4;
            2'd1:    tgt = v.fl[0] ? v.pc4 + 32'(off) : v.pc4 + 32'd4;
            2'd2:    tgt = (v.pc4 & 32'hF000_0000) | (32'(v.imm) << 2);
            default: tgt = pred ? m_ras[$] : v.rs;
        endcase
        if (v.fl[5])      nxt = 32'h0000_4180;
        else if (v.fl[6]) nxt = v.epc;
        else if (v.fl[7]) nxt = v.rtgt;
        else if (v.fl[4]) nxt = m_pc;
        else              nxt = tgt;
        if (v.fl[7:4] == 4'b0000) begin
            if (v.sel == 2'd3 && v.fl[2] && m_ras.size() > 0)
                void'(m_ras.pop_back());
            if (v.fl[1]) begin
                m_ras.push_back(v.pc4 + 32'd4);
                if (m_ras.size() > DEPTH)
                    void'(m_ras.pop_front());
            end
        end
        v.exp_pc   = nxt;
        v.exp_pred = pred;
        m_pc       = nxt;
    endtask

    initial begin
        vec_t v;
        n_cmp   = 0;
        n_fail  = 0;
        reset_n = 1'b1;

        // ---------------- directed table ----------------
        tbl[0]  = mk(NPC_SEQ, 32'h0000_3000, 26'h0,       32'h0,         8'h0,                     32'h0,         32'h0,         32'h0000_3004, 1'b0);
        tbl[1]  = mk(NPC_SEQ, 32'h0000_3004, 26'h0,       32'h0,         8'h0,                     32'h0,         32'h0,         32'h0000_3008, 1'b0);
        tbl[2]  = mk(NPC_BR,  32'h0000_3010, 26'h000FFFF, 32'h0,         F_CMP,                    32'h0,         32'h0,         32'h0000_300C, 1'b0);
        tbl[3]  = mk(NPC_BR,  32'h0000_3010, 26'h000FFFF, 32'h0,         8'h0,                     32'h0,         32'h0,         32'h0000_3014, 1'b0);
        tbl[4]  = mk(NPC_J,   32'h0000_3004, 26'h0000C10, 32'h0,         F_LINK,                   32'h0,         32'h0,         32'h0000_3040, 1'b0);
        tbl[5]  = mk(NPC_SEQ, 32'h0000_3040, 26'h0,       32'h0,         F_STALL,                  32'h0,         32'h0,         32'h0000_3040, 1'b0);
        tbl[6]  = mk(NPC_SEQ, 32'h0000_3040, 26'h0,       32'h0,         F_STALL|F_EXC|F_ERET,     32'h0000_5000, 32'h0,         32'h0000_4180, 1'b0);
        tbl[7]  = mk(NPC_SEQ, 32'h0000_3040, 26'h0,       32'h0,         F_STALL|F_ERET,           32'h0000_5000, 32'h0,         32'h0000_5000, 1'b0);
        tbl[8]  = mk(NPC_SEQ, 32'h0000_3040, 26'h0,       32'h0,         F_STALL|F_MISS,           32'h0,         32'h0000_3100, 32'h0000_3100, 1'b0);
        tbl[9]  = mk(NPC_J,   32'h0000_3040, 26'h0000100, 32'h0,         F_ERET|F_MISS|F_LINK,     32'h0000_6000, 32'h0000_3100, 32'h0000_6000, 1'b0);
        tbl[10] = mk(NPC_JR,  32'h0000_3050, 26'h0,       32'h0000_7000, 8'h0,                     32'h0,         32'h0,         32'h0000_7000, 1'b0);
        tbl[11] = mk(NPC_J,   32'hA000_0010, 26'h3FFFFFF, 32'h0,         8'h0,                     32'h0,         32'h0,         32'hAFFF_FFFC, 1'b0);
        tbl[12] = mk(NPC_BR,  32'hFFFF_FFFC, 26'h0000001, 32'h0,         F_CMP,                    32'h0,         32'h0,         32'h0000_0000, 1'b0);
        tbl[13] = mk(NPC_SEQ, 32'hFFFF_FFFC, 26'h0,       32'h0,         8'h0,                     32'h0,         32'h0,         32'h0000_0000, 1'b0);
        tbl[14] = mk(NPC_JR,  32'h0000_3060, 26'h0,       32'hBEEF_0000, F_ISRET|F_HAZ|F_STALL,    32'h0,         32'h0,         32'h0000_0000, 1'b1);
        tbl[15] = mk(NPC_JR,  32'h0000_3060, 26'h0,       32'hDEAD_0000, F_ISRET|F_HAZ,            32'h0,         32'h0,         32'h0000_3008, 1'b1);
        tbl[16] = mk(NPC_JR,  32'h0000_3060, 26'h0,       32'h0000_1234, F_ISRET|F_HAZ,            32'h0,         32'h0,         32'h0000_1234, 1'b0);

        do_reset();
        for (int i = 0; i < 17; i++)
            run_vec(tbl[i], $sformatf("tbl[%0d]", i));

        // ---------------- five pushes, then returns newest first ----------------
        do_reset();
        for (int i = 1; i <= 5; i++)
            run_vec(mk(NPC_J, 32'(i * 32'h100), 26'(i * 26'h40), 32'h0, F_LINK,
                       32'h0, 32'h0, 32'(i * 32'h100), 1'b0), $sformatf("jal%0d", i));
        for (int k = 0; k < 4; k++)
            run_vec(mk(NPC_JR, 32'h0000_2000, 26'h0, 32'h0000_9990, F_ISRET|F_HAZ,
                       32'h0, 32'h0, 32'h0000_0504 - 32'(k * 32'h100), 1'b1), $sformatf("ret%0d", k));
        run_vec(mk(NPC_JR, 32'h0000_2000, 26'h0, 32'h0000_9990, F_ISRET|F_HAZ,
                   32'h0, 32'h0, 32'h0000_9990, 1'b0), "ret_empty");

        // ---------------- predicted return then E-stage mispredict ----------------
        run_vec(mk(NPC_J, 32'h0000_0600, 26'h20, 32'h0, F_LINK, 32'h0, 32'h0, 32'h0000_0080, 1'b0), "miss.jal");
        run_vec(mk(NPC_JR, 32'h0000_0084, 26'h0, 32'h0000_0ABC, F_ISRET|F_HAZ, 32'h0, 32'h0, 32'h0000_0604, 1'b1), "miss.jr");
        run_vec(mk(NPC_SEQ, 32'h0000_0700, 26'h0, 32'h0, F_MISS, 32'h0, 32'h0000_3100, 32'h0000_3100, 1'b0), "miss.fix");

        // ---------------- full stack: jalr $31,$31 replaces top ----------------
        for (int i = 1; i <= 4; i++)
            run_vec(mk(NPC_J, 32'h0000_1000, 26'(i), 32'h0, F_LINK, 32'h0, 32'h0, 32'(i * 4), 1'b0),
                    $sformatf("fill%0d", i));
        run_vec(mk(NPC_JR, 32'h0000_1800, 26'h0, 32'h0000_0400, F_ISRET|F_HAZ|F_LINK,
                   32'h0, 32'h0, 32'h0000_1004, 1'b1), "jalr31");
        run_vec(mk(NPC_JR, 32'h0000_1900, 26'h0, 32'h0000_0400, F_ISRET|F_HAZ,
                   32'h0, 32'h0, 32'h0000_1804, 1'b1), "jalr31.top");
        run_vec(mk(NPC_JR, 32'h0000_1900, 26'h0, 32'h0000_0400, F_ISRET|F_HAZ,
                   32'h0, 32'h0, 32'h0000_1004, 1'b1), "jalr31.next");

        // ---------------- asynchronous reset mid-run ----------------
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst.fpc", bus.F_PC, 32'h0000_3000);
        drive(mk(NPC_JR, 32'h0000_2000, 26'h0, 32'h0000_0040, F_ISRET|F_HAZ, 32'h0, 32'h0, 32'h0, 1'b0));
        #1;
        check("midrst.pred", {31'd0, bus.ras_pred}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        run_vec(mk(NPC_JR, 32'h0000_2000, 26'h0, 32'h0000_0040, F_ISRET|F_HAZ,
                   32'h0, 32'h0, 32'h0000_0040, 1'b0), "postrst");

        // ---------------- randomized phase against the model ----------------
        do_reset();
        for (int n = 0; n < 400; n++) begin
            v.sel  = 2'($urandom_range(0, 3));
            v.pc4  = $urandom & 32'hFFFF_FFFC;
            v.imm  = 26'($urandom);
            v.rs   = $urandom & 32'hFFFF_FFFC;
            v.epc  = $urandom & 32'hFFFF_FFFC;
            v.rtgt = $urandom & 32'hFFFF_FFFC;
            v.fl   = 8'h0;
            v.fl[0] = 1'($urandom_range(0, 1));
            v.fl[1] = (v.sel >= 2'd2) ? 1'($urandom_range(0, 1)) : 1'b0;
            v.fl[2] = (v.sel == 2'd3) ? 1'($urandom_range(0, 1)) : 1'b0;
            v.fl[3] = 1'($urandom_range(0, 1));
            v.fl[4] = ($urandom_range(0, 3) == 0);
            v.fl[5] = ($urandom_range(0, 15) == 0);
            v.fl[6] = ($urandom_range(0, 15) == 0);
            v.fl[7] = ($urandom_range(0, 7) == 0);
            model_fill(v);
            run_vec(v, $sformatf("rnd[%0d]", n));
            check($sformatf("rnd[%0d].adel", n), {31'd0, bus.F_AdEL}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
